// File: rtl/full_adder_dataflow_reg_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands; the slave (the adder) returns registered results.
interface full_adder_dataflow_reg_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             in_valid;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             ovf;
  logic             out_valid;

  modport master (
    output A, B, C_in, in_valid,
    input  S, C_out, ovf, out_valid
  );

  modport slave (
    input  A, B, C_in, in_valid,
    output S, C_out, ovf, out_valid
  );
endinterface

// File: rtl/full_adder_dataflow_reg.sv
// Registered WIDTH-bit ripple-carry adder built from dataflow full-adder cells.
// Results (sum, carry out, signed overflow) appear one cycle after in_valid.

module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module full_adder_dataflow_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  full_adder_dataflow_reg_if.slave  bus
);
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             valid_q;

  assign carry[0] = bus.C_in;

  // Plain ripple chain, LSB to MSB, no lookahead.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a_i (bus.A[i]),
      .b_i (bus.B[i]),
      .c_i (carry[i]),
      .s_o (sum[i]),
      .c_o (carry[i+1])
    );
  end

  // NOTE: the hold value is the default so no path leaves a signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    if (bus.in_valid) begin
      s_d     = sum;
      c_out_d = carry[WIDTH];
      ovf_d   = carry[WIDTH-1] ^ carry[WIDTH];
    end
  end

  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      valid_q <= bus.in_valid;
    end
  end

  assign bus.S         = s_q;
  assign bus.C_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_full_adder_dataflow_reg.sv
// Directed and random checks of the registered adder at WIDTH 1, 8 and 16.
module tb_full_adder_dataflow_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  full_adder_dataflow_reg_if #(.WIDTH(1))  if_w1  ();
  full_adder_dataflow_reg_if #(.WIDTH(8))  if_w8  ();
  full_adder_dataflow_reg_if #(.WIDTH(16)) if_w16 ();

  full_adder_dataflow_reg #(.WIDTH(1))  u_w1  (.clk(clk), .rst(rst), .bus(if_w1.slave));
  full_adder_dataflow_reg #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .bus(if_w8.slave));
  full_adder_dataflow_reg #(.WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .bus(if_w16.slave));

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       cout, ovf;
  } vec8_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic v);
    if_w8.A = a; if_w8.B = b; if_w8.C_in = cin; if_w8.in_valid = v;
  endtask

  initial begin
    logic [1:0]  w1_exp [8];
    vec8_t       v8 [4];
    logic [2:0]  abc;
    logic [15:0] ra, rb;
    logic        rc, rv;
    logic [16:0] rsum;
    logic [15:0] h_s;
    logic        h_c, h_o, r_ovf;

    // {S, C_out} for (A,B,C_in) = 000 .. 111
    w1_exp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    v8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    v8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    v8[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    v8[3] = '{8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 1'b1};

    if_w1.A = '0;  if_w1.B = '0;  if_w1.C_in = 1'b0;  if_w1.in_valid = 1'b0;
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    if_w16.A = '0; if_w16.B = '0; if_w16.C_in = 1'b0; if_w16.in_valid = 1'b0;

    rst = 1'b1;
    step();
    step();
    check("rst_w8_s",     64'(if_w8.S), 64'h0);
    check("rst_w8_cout",  64'(if_w8.C_out), 64'h0);
    check("rst_w8_ovf",   64'(if_w8.ovf), 64'h0);
    check("rst_w8_valid", 64'(if_w8.out_valid), 64'h0);
    check("rst_w1_valid", 64'(if_w1.out_valid), 64'h0);
    check("rst_w16_s",    64'(if_w16.S), 64'h0);
    rst = 1'b0;

    // WIDTH=1 exhaustive sweep, one vector per cycle
    for (int v = 0; v < 8; v++) begin
      abc = 3'(v);
      if_w1.A = abc[2]; if_w1.B = abc[1]; if_w1.C_in = abc[0]; if_w1.in_valid = 1'b1;
      step();
      check($sformatf("w1_sc_%0d", v), 64'({if_w1.S, if_w1.C_out}), 64'(w1_exp[v]));
      check($sformatf("w1_valid_%0d", v), 64'(if_w1.out_valid), 64'h1);
    end
    if_w1.in_valid = 1'b0;

    // WIDTH=8 directed corner cases
    for (int i = 0; i < 4; i++) begin
      drive8(v8[i].a, v8[i].b, v8[i].cin, 1'b1);
      step();
      check($sformatf("w8_s_%0d", i),    64'(if_w8.S), 64'(v8[i].s));
      check($sformatf("w8_cout_%0d", i), 64'(if_w8.C_out), 64'(v8[i].cout));
      check($sformatf("w8_ovf_%0d", i),  64'(if_w8.ovf), 64'(v8[i].ovf));
    end

    // Hold: one valid add, then three idle cycles with moving operands
    drive8(8'h12, 8'h34, 1'b0, 1'b1);
    step();
    check("hold_s0",     64'(if_w8.S), 64'h46);
    check("hold_valid0", 64'(if_w8.out_valid), 64'h1);
    for (int i = 1; i <= 3; i++) begin
      drive8(8'(8'hA5 ^ i), 8'(8'h5A + i), 1'(i), 1'b0);
      step();
      check($sformatf("hold_s%0d", i),     64'(if_w8.S), 64'h46);
      check($sformatf("hold_cout%0d", i),  64'(if_w8.C_out), 64'h0);
      check($sformatf("hold_valid%0d", i), 64'(if_w8.out_valid), 64'h0);
    end

    // Reset wins over a valid operand set
    drive8(8'hFF, 8'hFF, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    check("mrst_s",     64'(if_w8.S), 64'h0);
    check("mrst_cout",  64'(if_w8.C_out), 64'h0);
    check("mrst_ovf",   64'(if_w8.ovf), 64'h0);
    check("mrst_valid", 64'(if_w8.out_valid), 64'h0);
    rst = 1'b0;
    drive8(8'h01, 8'h01, 1'b0, 1'b1);
    step();
    check("post_rst_s",     64'(if_w8.S), 64'h02);
    check("post_rst_valid", 64'(if_w8.out_valid), 64'h1);
    drive8(8'h00, 8'h00, 1'b0, 1'b0);

    // WIDTH=16 random stream; DUT was last reset so held values start at 0
    h_s = '0; h_c = 1'b0; h_o = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rv = 1'($urandom);
      if_w16.A = ra; if_w16.B = rb; if_w16.C_in = rc; if_w16.in_valid = rv;
      step();
      if (rv) begin
        rsum  = {1'b0, ra} + {1'b0, rb} + 17'(rc);
        r_ovf = (ra[15] == rb[15]) && (rsum[15] != ra[15]);
        h_s = rsum[15:0]; h_c = rsum[16]; h_o = r_ovf;
      end
      check($sformatf("r16_valid_%0d", i), 64'(if_w16.out_valid), 64'(rv));
      check($sformatf("r16_sum_%0d", i),   64'({if_w16.C_out, if_w16.S}), 64'({h_c, h_s}));
      check($sformatf("r16_ovf_%0d", i),   64'(if_w16.ovf), 64'(h_o));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
